// File: rtl/readcode_burst.sv
// rtl/readcode_burst.sv - icache readcode responder: one 16-byte line per request, critical word first,
// split into a wrapping burst A (start..3) and burst B (0..start-1) on the Avalon-style memory port.
module readcode_burst (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_readcode_do,
  input  logic [31:0]  i_readcode_address,
  output logic         o_readcode_done,
  output logic [127:0] o_readcode_line,
  output logic [31:0]  o_readcode_partial,
  output logic         o_readcode_partial_done,
  output logic [31:0]  o_mem_address,
  output logic         o_mem_read,
  output logic [2:0]   o_mem_burstcount,
  input  logic         i_mem_waitrequest,
  input  logic [31:0]  i_mem_readdata,
  input  logic         i_mem_readdatavalid
);

  typedef enum logic [1:0] {S_IDLE, S_CMD_A, S_CMD_B, S_DATA} state_t;

  state_t       r_state;
  state_t       w_next;
  logic [27:0]  r_base;
  logic [1:0]   r_start;
  logic [2:0]   r_beat;
  logic [27:0]  w_base_nxt;
  logic [1:0]   w_start_nxt;
  logic         w_accept;
  logic         w_capture;
  logic         w_last;
  logic [1:0]   w_word;

  logic         r_done;
  logic [127:0] r_line;
  logic [31:0]  r_partial;
  logic         r_partial_done;
  logic [31:0]  r_mem_address;
  logic         r_mem_read;
  logic [2:0]   r_mem_burstcount;

  assign w_accept    = (r_state == S_IDLE) && i_readcode_do;
  assign w_capture   = (r_state != S_IDLE) && i_mem_readdatavalid;
  assign w_last      = w_capture && (r_beat == 3'd3);
  assign w_word      = r_start + r_beat[1:0];
  assign w_base_nxt  = w_accept ? i_readcode_address[31:4] : r_base;
  assign w_start_nxt = w_accept ? i_readcode_address[3:2] : r_start;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_readcode_do) w_next = S_CMD_A;
      S_CMD_A: if (!i_mem_waitrequest) w_next = (r_start != 2'd0) ? S_CMD_B : S_DATA;
      S_CMD_B: if (!i_mem_waitrequest) w_next = S_DATA;
      default: w_next = r_state;
    endcase
    // The fourth beat ends the line even if the FSM is still nominally issuing.
    if (w_last) w_next = S_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_base           <= '0;
      r_start          <= '0;
      r_beat           <= '0;
      r_done           <= 1'b0;
      r_line           <= '0;
      r_partial        <= '0;
      r_partial_done   <= 1'b0;
      r_mem_address    <= '0;
      r_mem_read       <= 1'b0;
      r_mem_burstcount <= '0;
    end else begin
      r_done         <= 1'b0;
      r_partial_done <= 1'b0;
      if (w_accept) begin
        r_base  <= w_base_nxt;
        r_start <= w_start_nxt;
        r_beat  <= 3'd0;
      end
      // Command outputs are a registered decode of the next state, so they hold through stalls.
      case (w_next)
        S_CMD_A: begin
          r_mem_read       <= 1'b1;
          r_mem_address    <= {w_base_nxt, w_start_nxt, 2'b00};
          r_mem_burstcount <= 3'd4 - {1'b0, w_start_nxt};
        end
        S_CMD_B: begin
          r_mem_read       <= 1'b1;
          r_mem_address    <= {w_base_nxt, 4'h0};
          r_mem_burstcount <= {1'b0, w_start_nxt};
        end
        default: begin
          r_mem_read       <= 1'b0;
          r_mem_address    <= '0;
          r_mem_burstcount <= '0;
        end
      endcase
      if (w_capture) begin
        r_line[{w_word, 5'd0} +: 32] <= i_mem_readdata;
        r_partial                    <= i_mem_readdata;
        r_partial_done               <= 1'b1;
        r_beat                       <= r_beat + 3'd1;
        r_done                       <= w_last;
      end
    end
  end

  assign o_readcode_done         = r_done;
  assign o_readcode_line         = r_line;
  assign o_readcode_partial      = r_partial;
  assign o_readcode_partial_done = r_partial_done;
  assign o_mem_address           = r_mem_address;
  assign o_mem_read              = r_mem_read;
  assign o_mem_burstcount        = r_mem_burstcount;

endmodule

// File: tb/tb_readcode_burst.sv
// tb/tb_readcode_burst.sv - directed bench for readcode_burst; memory side driven by hand, cycle by cycle.
module tb_readcode_burst;

  logic         clk = 1'b0;
  logic         rst;
  logic         readcode_do;
  logic [31:0]  readcode_address;
  logic         readcode_done;
  logic [127:0] readcode_line;
  logic [31:0]  readcode_partial;
  logic         readcode_partial_done;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic [2:0]   mem_burstcount;
  logic         mem_waitrequest;
  logic [31:0]  mem_readdata;
  logic         mem_readdatavalid;

  int n_assert = 0;
  int n_fail   = 0;
  int n_pd     = 0;
  int n_done   = 0;

  readcode_burst dut (
    .i_clk                   (clk),
    .i_rst                   (rst),
    .i_readcode_do           (readcode_do),
    .i_readcode_address      (readcode_address),
    .o_readcode_done         (readcode_done),
    .o_readcode_line         (readcode_line),
    .o_readcode_partial      (readcode_partial),
    .o_readcode_partial_done (readcode_partial_done),
    .o_mem_address           (mem_address),
    .o_mem_read              (mem_read),
    .o_mem_burstcount        (mem_burstcount),
    .i_mem_waitrequest       (mem_waitrequest),
    .i_mem_readdata          (mem_readdata),
    .i_mem_readdatavalid     (mem_readdatavalid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (readcode_partial_done) n_pd++;
    if (readcode_done) n_done++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input string tag, input logic [31:0] a, input logic [2:0] c);
    chk({tag, "_read"}, {127'd0, mem_read}, 128'd1);
    chk({tag, "_addr"}, {96'd0, mem_address}, {96'd0, a});
    chk({tag, "_count"}, {125'd0, mem_burstcount}, {125'd0, c});
  endtask

  task automatic feed(input string tag, input logic [31:0] d, input logic last);
    mem_readdatavalid = 1'b1;
    mem_readdata      = d;
    tick();
    mem_readdatavalid = 1'b0;
    chk({tag, "_pd"}, {127'd0, readcode_partial_done}, 128'd1);
    chk({tag, "_partial"}, {96'd0, readcode_partial}, {96'd0, d});
    chk({tag, "_done"}, {127'd0, readcode_done}, {127'd0, last});
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_done"}, {127'd0, readcode_done}, 128'd0);
    chk({tag, "_pd"}, {127'd0, readcode_partial_done}, 128'd0);
    chk({tag, "_read"}, {127'd0, mem_read}, 128'd0);
    chk({tag, "_addr"}, {96'd0, mem_address}, 128'd0);
    chk({tag, "_count"}, {125'd0, mem_burstcount}, 128'd0);
    chk({tag, "_partial"}, {96'd0, readcode_partial}, 128'd0);
    chk({tag, "_line"}, readcode_line, 128'd0);
  endtask

  initial begin
    rst = 1'b1; readcode_do = 1'b0; readcode_address = '0;
    mem_waitrequest = 1'b0; mem_readdata = '0; mem_readdatavalid = 1'b0;
    tick(); tick();
    all_zero("reset");
    rst = 1'b0;
    tick();

    // Aligned fetch, no wait states: done lands five cycles after the command.
    readcode_do = 1'b1; readcode_address = 32'h0001_0000;
    tick();
    readcode_do = 1'b0;
    cmd("al_cmd", 32'h0001_0000, 3'd4);
    tick();
    chk("al_single_burst", {127'd0, mem_read}, 128'd0);
    feed("al_b0", 32'h1111_1111, 1'b0);
    feed("al_b1", 32'h2222_2222, 1'b0);
    feed("al_b2", 32'h3333_3333, 1'b0);
    feed("al_b3", 32'h4444_4444, 1'b1);
    chk("al_line", readcode_line, 128'h44444444_33333333_22222222_11111111);

    // Back-to-back: start word 2 requested in the done cycle.
    readcode_do = 1'b1; readcode_address = 32'h0001_0008;
    tick();
    readcode_do = 1'b0;
    cmd("s2_cmd_a", 32'h0001_0008, 3'd2);
    tick();
    cmd("s2_cmd_b", 32'h0001_0000, 3'd2);
    feed("s2_w2", 32'hAAAA_0002, 1'b0);
    chk("s2_read_off", {127'd0, mem_read}, 128'd0);
    feed("s2_w3", 32'hAAAA_0003, 1'b0);
    feed("s2_w0", 32'hAAAA_0000, 1'b0);
    feed("s2_w1", 32'hAAAA_0001, 1'b1);
    chk("s2_line", readcode_line, 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000);

    // Start word 3 with three stall cycles on burst A.
    readcode_do = 1'b1; readcode_address = 32'h0001_000C; mem_waitrequest = 1'b1;
    tick();
    readcode_do = 1'b0;
    cmd("s3_stall0", 32'h0001_000C, 3'd1);
    tick();
    cmd("s3_stall1", 32'h0001_000C, 3'd1);
    tick();
    cmd("s3_stall2", 32'h0001_000C, 3'd1);
    mem_waitrequest = 1'b0;
    tick();
    cmd("s3_cmd_b", 32'h0001_0000, 3'd3);
    feed("s3_w3", 32'hCC00_0003, 1'b0);
    feed("s3_w0", 32'hCC00_0000, 1'b0);
    feed("s3_w1", 32'hCC00_0001, 1'b0);
    feed("s3_w2", 32'hCC00_0002, 1'b1);
    chk("s3_line", readcode_line, 128'hCC000003_CC000002_CC000001_CC000000);

    // Request while busy is ignored.
    tick();
    n_pd = 0; n_done = 0;
    readcode_do = 1'b1; readcode_address = 32'h0003_0004;
    tick();
    readcode_do = 1'b0;
    cmd("bz_cmd_a", 32'h0003_0004, 3'd3);
    tick();
    cmd("bz_cmd_b", 32'h0003_0000, 3'd1);
    tick();
    feed("bz_w1", 32'hD000_0001, 1'b0);
    readcode_do = 1'b1; readcode_address = 32'h0005_0000;
    feed("bz_w2", 32'hD000_0002, 1'b0);
    readcode_do = 1'b0;
    chk("bz_no_cmd", {127'd0, mem_read}, 128'd0);
    feed("bz_w3", 32'hD000_0003, 1'b0);
    feed("bz_w0", 32'hD000_0000, 1'b1);
    chk("bz_line", readcode_line, 128'hD0000003_D0000002_D0000001_D0000000);
    tick(); tick(); tick(); tick();
    chk("bz_pd_count", 128'(n_pd), 128'd4);
    chk("bz_done_count", 128'(n_done), 128'd1);
    chk("bz_idle", {127'd0, mem_read}, 128'd0);

    // Reset after two beats, then stale data arrives.
    n_pd = 0; n_done = 0;
    readcode_do = 1'b1; readcode_address = 32'h0004_0000;
    tick();
    readcode_do = 1'b0;
    cmd("rs_cmd", 32'h0004_0000, 3'd4);
    tick();
    feed("rs_b0", 32'hE000_0000, 1'b0);
    feed("rs_b1", 32'hE000_0001, 1'b0);
    rst = 1'b1; mem_readdatavalid = 1'b1; mem_readdata = 32'hE000_0002;
    tick();
    all_zero("rs_reset");
    rst = 1'b0; mem_readdata = 32'hE000_0003;
    tick();
    mem_readdata = 32'hE000_0004;
    tick();
    mem_readdatavalid = 1'b0;
    tick();
    all_zero("rs_stale");
    chk("rs_pd_count", 128'(n_pd), 128'd2);
    chk("rs_done_count", 128'(n_done), 128'd0);

    // Request after reset completes normally.
    readcode_do = 1'b1; readcode_address = 32'h0005_0004;
    tick();
    readcode_do = 1'b0;
    cmd("ar_cmd_a", 32'h0005_0004, 3'd3);
    tick();
    cmd("ar_cmd_b", 32'h0005_0000, 3'd1);
    tick();
    feed("ar_w1", 32'hF000_0001, 1'b0);
    feed("ar_w2", 32'hF000_0002, 1'b0);
    feed("ar_w3", 32'hF000_0003, 1'b0);
    feed("ar_w0", 32'hF000_0000, 1'b1);
    chk("ar_line", readcode_line, 128'hF0000003_F0000002_F0000001_F0000000);
    tick();
    chk("ar_done_pulse", {127'd0, readcode_done}, 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
